// File: rtl/des_wb_ctrl.sv
// des_wb_ctrl: Wishbone register front end and one-shot sequencer for the DES engine.
module des_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          TIMEOUT   = 64,
  parameter int          TO_W      = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic [31:0] o_wb_data,
  output logic        o_des_start,
  output logic        o_des_decrypt,
  output logic [63:0] o_des_key,
  output logic [63:0] o_des_din,
  input  logic        i_des_done,
  input  logic [63:0] i_des_dout,
  output logic        o_irq
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;
  state_t state_q, state_d;
  logic ack_q, decrypt_q, irq_en_q, done_q, err_q;
  logic [31:0] rdata_q, rdata;
  logic [63:0] key_q, din_q, dout_q;
  logic [TO_W-1:0] cnt_q;
  logic req, wr, busy, start, done_hit, timeout, ctrl_wr, stat_wr, unused_ok;
  logic [5:0] off;

  function automatic logic [31:0] bw(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    return {s[3] ? d[31:24] : o[31:24], s[2] ? d[23:16] : o[23:16],
            s[1] ? d[15:8] : o[15:8], s[0] ? d[7:0] : o[7:0]};
  endfunction

  // A request is not sampled in the ack cycle, so acks can never be back to back.
  assign req       = i_wb_cyc & i_wb_stb & ~ack_q & (i_wb_addr[31:8] == BASE_ADDR[31:8]);
  assign wr        = req & i_wb_we;
  assign off       = i_wb_addr[7:2];
  assign busy      = state_q != IDLE;
  assign ctrl_wr   = wr && off == 6'd0 && i_wb_sel[0];
  assign stat_wr   = wr && off == 6'd1 && i_wb_sel[0];
  assign start     = ctrl_wr && i_wb_data[0] && !busy;
  assign done_hit  = state_q == WAIT && i_des_done;
  assign timeout   = state_q == WAIT && !i_des_done && cnt_q == TO_W'(TIMEOUT - 1);
  assign unused_ok = ^i_wb_addr[1:0];

  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;

  always_comb
    state_d = state_q == IDLE ? (start ? LOAD : IDLE) :
              state_q == LOAD ? WAIT :
              (done_hit || timeout) ? IDLE : WAIT;

  always_comb begin
    o_des_start   = state_q == LOAD;
    o_irq         = done_q & irq_en_q;
    o_wb_ack      = ack_q;
    o_wb_data     = rdata_q;
    o_des_decrypt = decrypt_q;
    o_des_key     = key_q;
    o_des_din     = din_q;
  end

  always_comb
    rdata = off == 6'd0 ? {29'd0, irq_en_q, decrypt_q, 1'b0} :
            off == 6'd1 ? {29'd0, err_q, done_q, busy} :
            off == 6'd2 ? key_q[63:32] :
            off == 6'd3 ? key_q[31:0] :
            off == 6'd4 ? din_q[63:32] :
            off == 6'd5 ? din_q[31:0] :
            off == 6'd6 ? dout_q[63:32] :
            off == 6'd7 ? dout_q[31:0] : 32'd0;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      decrypt_q <= 1'b0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      key_q     <= '0;
      din_q     <= '0;
      dout_q    <= '0;
      cnt_q     <= '0;
    end else begin
      ack_q   <= req;
      rdata_q <= (req && !i_wb_we) ? rdata : '0;
      cnt_q   <= state_q == WAIT ? cnt_q + 1'b1 : '0;
      if (ctrl_wr) irq_en_q <= i_wb_data[2];
      if (ctrl_wr && !busy) decrypt_q <= i_wb_data[1];
      // Engine completion wins over a simultaneous software clear.
      done_q <= done_hit | (done_q & ~(stat_wr & i_wb_data[1]));
      err_q  <= timeout | (err_q & ~(stat_wr & i_wb_data[2]));
      if (done_hit) dout_q <= i_des_dout;
      if (wr && !busy) begin
        if (off == 6'd2) key_q[63:32] <= bw(key_q[63:32], i_wb_data, i_wb_sel);
        if (off == 6'd3) key_q[31:0]  <= bw(key_q[31:0], i_wb_data, i_wb_sel);
        if (off == 6'd4) din_q[63:32] <= bw(din_q[63:32], i_wb_data, i_wb_sel);
        if (off == 6'd5) din_q[31:0]  <= bw(din_q[31:0], i_wb_data, i_wb_sel);
      end
    end
endmodule

// File: tb/tb_des_wb_ctrl.sv
// tb_des_wb_ctrl: directed and randomized checks of des_wb_ctrl against a register-level model.
module tb_des_wb_ctrl;
  localparam int T = 64;
  localparam logic [31:0] BASE = 32'h3000_0000;
  logic clk = 0, reset = 1;
  logic i_wb_cyc = 0, i_wb_stb = 0, i_wb_we = 0;
  logic [3:0] i_wb_sel = 0;
  logic [31:0] i_wb_addr = 0, i_wb_data = 0;
  logic o_wb_ack, o_des_start, o_des_decrypt, o_irq;
  logic [31:0] o_wb_data;
  logic [63:0] o_des_key, o_des_din;
  logic i_des_done = 0;
  logic [63:0] i_des_dout = 0;

  des_wb_ctrl #(.BASE_ADDR(BASE), .TIMEOUT(T), .TO_W(7)) dut (
    .clk(clk), .reset(reset), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_sel(i_wb_sel), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .o_wb_ack(o_wb_ack),
    .o_wb_data(o_wb_data), .o_des_start(o_des_start), .o_des_decrypt(o_des_decrypt),
    .o_des_key(o_des_key), .o_des_din(o_des_din), .i_des_done(i_des_done),
    .i_des_dout(i_des_dout), .o_irq(o_irq));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, starts_seen = 0, acks = 0, m_starts = 0;
  always @(posedge clk) begin
    if (o_des_start) starts_seen++;
    if (o_wb_ack) acks++;
  end

  // Register-level model: what software should observe.
  bit m_busy, m_dec, m_irq, m_done, m_err;
  logic [63:0] m_key, m_din, m_dout;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) o[8*i +: 8] = d[8*i +: 8];
    return o;
  endfunction

  function automatic logic [31:0] m_read(input int off);
    case (off)
      0: return {29'd0, m_irq, m_dec, 1'b0};
      1: return {29'd0, m_err, m_done, m_busy};
      2: return m_key[63:32];
      3: return m_key[31:0];
      4: return m_din[63:32];
      5: return m_din[31:0];
      6: return m_dout[63:32];
      7: return m_dout[31:0];
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_write(input int off, input logic [31:0] d, input logic [3:0] s);
    if (off == 0 && s[0]) begin
      m_irq = d[2];
      if (!m_busy) m_dec = d[1];
      if (!m_busy && d[0]) begin m_busy = 1; m_starts++; end
    end
    if (off == 1 && s[0]) begin
      if (d[1]) m_done = 0;
      if (d[2]) m_err = 0;
    end
    if (!m_busy) begin
      if (off == 2) m_key[63:32] = merge(m_key[63:32], d, s);
      if (off == 3) m_key[31:0]  = merge(m_key[31:0], d, s);
      if (off == 4) m_din[63:32] = merge(m_din[63:32], d, s);
      if (off == 5) m_din[31:0]  = merge(m_din[31:0], d, s);
    end
  endtask

  task automatic m_done_evt(input logic [63:0] dd);
    if (m_busy) begin m_dout = dd; m_done = 1; m_busy = 0; end
  endtask

  task automatic m_clear();
    {m_busy, m_dec, m_irq, m_done, m_err} = '0;
    m_key = 0; m_din = 0; m_dout = 0;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, " key"}, o_des_key, m_key);
    chk({tag, " din"}, o_des_din, m_din);
    chk({tag, " dec"}, {63'd0, o_des_decrypt}, {63'd0, m_dec});
    chk({tag, " irq"}, {63'd0, o_irq}, {63'd0, m_done & m_irq});
    chk({tag, " starts"}, starts_seen, m_starts);
  endtask

  task automatic bus(input int off, input logic we, input logic [31:0] d, input logic [3:0] s,
                     input bit with_done, input logic [63:0] dd, input string tag);
    logic [31:0] exp;
    @(negedge clk);
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = we; i_wb_addr = BASE + 32'(off * 4);
    i_wb_data = d; i_wb_sel = s;
    if (with_done) begin i_des_done = 1; i_des_dout = dd; end
    exp = we ? 32'd0 : m_read(off);
    @(posedge clk); #1;
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0; i_des_done = 0;
    chk({tag, " ack"}, {63'd0, o_wb_ack}, 64'd1);
    chk({tag, " data"}, {32'd0, o_wb_data}, {32'd0, exp});
    if (we) m_write(off, d, s);
    if (with_done) m_done_evt(dd);
    @(posedge clk); #1;
    chk({tag, " ack low"}, {63'd0, o_wb_ack}, 64'd0);
    chk({tag, " data idle"}, {32'd0, o_wb_data}, 64'd0);
    chk_outs(tag);
  endtask

  task automatic wr(input int off, input logic [31:0] d, input logic [3:0] s, input string tag);
    bus(off, 1, d, s, 0, 0, tag);
  endtask

  task automatic rd(input int off, input string tag);
    bus(off, 0, 0, 4'hf, 0, 0, tag);
  endtask

  task automatic pulse_done(input logic [63:0] dd, input int delay);
    repeat (delay) @(posedge clk);
    @(negedge clk); i_des_done = 1; i_des_dout = dd;
    @(posedge clk); #1; i_des_done = 0;
    m_done_evt(dd);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); reset = 1; #1;
    chk({tag, " async key"}, o_des_key, 64'd0);
    chk({tag, " async start"}, {63'd0, o_des_start}, 64'd0);
    m_clear();
    @(negedge clk); reset = 0;
  endtask

  task automatic timeout_op(input int m, input string tag);
    wr(0, 32'h1, 4'h1, {tag, " start"});
    repeat (m) @(posedge clk);
    if (m >= T) begin m_busy = 0; m_err = 1; end
    rd(1, {tag, " status"});
    m_busy = 0; m_err = 1;
    rd(1, {tag, " status end"});
    rd(6, {tag, " dout hi"});
    rd(7, {tag, " dout lo"});
  endtask

  int off, acks0;
  logic [31:0] d;
  logic [3:0] s;

  initial begin
    m_clear();
    #1;
    chk("reset ack", {63'd0, o_wb_ack}, 64'd0);
    chk("reset irq", {63'd0, o_irq}, 64'd0);
    chk("reset data", {32'd0, o_wb_data}, 64'd0);
    chk("reset key", o_des_key, 64'd0);
    @(negedge clk); @(negedge clk); reset = 0;
    for (int i = 0; i < 8; i++) rd(i, "t1 read");

    wr(2, 32'h13345779, 4'hf, "t2 key hi");
    wr(3, 32'h9BBCDFF1, 4'hf, "t2 key lo");
    wr(4, 32'h01234567, 4'hf, "t2 din hi");
    wr(5, 32'h89ABCDEF, 4'hf, "t2 din lo");
    wr(0, 32'h1, 4'h1, "t2 start");
    chk("t2 start pulse low", {63'd0, o_des_start}, 64'd0);
    rd(1, "t2 status busy");
    pulse_done(64'h85E813540F0AB405, 12);
    rd(1, "t2 status done");
    rd(6, "t2 dout hi");
    rd(7, "t2 dout lo");

    wr(0, 32'h4, 4'h1, "t3 irq_en");
    wr(1, 32'h2, 4'h1, "t3 w1c");
    wr(0, 32'h5, 4'h1, "t3 start");
    pulse_done(64'hDEADBEEF_CAFEF00D, 3);
    chk("t3 irq set", {63'd0, o_irq}, 64'd1);
    wr(1, 32'h2, 4'h1, "t3 w1c after");
    chk("t3 irq clear", {63'd0, o_irq}, 64'd0);
    wr(0, 32'h5, 4'h1, "t3 start2");
    bus(1, 1, 32'h2, 4'h1, 1, 64'h1111_2222_3333_4444, "t3 w1c+done");
    rd(1, "t3 set wins");

    timeout_op(T - 1, "t4a");
    wr(1, 32'h4, 4'h1, "t4 clr err");
    timeout_op(T, "t4b");
    wr(1, 32'h6, 4'h1, "t4 clr all");

    wr(0, 32'h1, 4'h1, "t5 start");
    wr(3, 32'hFFFFFFFF, 4'hf, "t5 key lo busy");
    wr(0, 32'h3, 4'h1, "t5 restart busy");
    rd(3, "t5 key lo");
    pulse_done(64'h0F0F_0F0F_F0F0_F0F0, 2);
    rd(1, "t5 status");
    rd(0, "t5 ctrl");

    do_reset("t6 reset");
    wr(5, 32'hAABBCCDD, 4'b0010, "t6 byte wr");
    rd(5, "t6 din lo");
    acks0 = acks;
    @(negedge clk);
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_addr = 32'h3100_0000;
    repeat (3) @(posedge clk); #1;
    chk("t6 off-window ack", acks, acks0);
    chk("t6 off-window data", {32'd0, o_wb_data}, 64'd0);
    i_wb_cyc = 0; i_wb_stb = 0;
    wr(0, 32'h1, 4'h1, "t6 start");
    repeat (5) @(posedge clk);
    do_reset("t6 mid-op reset");
    rd(1, "t6 status");
    rd(7, "t6 dout lo");
    pulse_done(64'h1234_5678_9ABC_DEF0, 0);
    rd(1, "t6 idle done status");
    rd(6, "t6 idle done dout");

    for (int i = 0; i < 60; i++) begin
      off = $urandom_range(0, 9);
      d = $urandom;
      s = 4'($urandom);
      if (off == 0) d[0] = 1'b0;
      if ($urandom_range(0, 1) == 1) wr(off, d, s, "rnd wr");
      else rd(off, "rnd rd");
      if (i % 10 == 9) begin
        wr(0, {29'd0, 1'($urandom), 1'($urandom), 1'b1}, 4'h1, "rnd start");
        pulse_done({$urandom, $urandom}, $urandom_range(0, 20));
        rd(1, "rnd status");
        rd(6, "rnd dout hi");
        rd(7, "rnd dout lo");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
